// File: rtl/writeback_unit.sv
`default_nettype none
// ============================================================================
// Module   : writeback_unit
// Purpose  : Merges ALU results and buffered load data onto the single
//            register-file write port, with R0 side-channel and busy mask.
// Revision : 1.0  initial release
// ============================================================================
module writeback_unit #(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   alu_valid,
    input  logic [3:0]             alu_dest,
    input  logic [15:0]            alu_data,
    input  logic                   alu_r0_en,
    input  logic [15:0]            alu_r0_data,
    input  logic                   mem_valid,
    output logic                   mem_ready,
    input  logic [3:0]             mem_dest,
    input  logic [15:0]            mem_data,
    output logic                   registerWrite,
    output logic [3:0]             regWriteLocal,
    output logic [15:0]            dataWrite,
    output logic [15:0]            r0Write,
    output logic [15:0]            busy_mask,
    output logic [$clog2(DEPTH):0] pending_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [3:0]    fifo_dest_q [DEPTH];
    logic [3:0]    fifo_dest_d [DEPTH];
    logic [15:0]   fifo_data_q [DEPTH];
    logic [15:0]   fifo_data_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [15:0]   r0_shadow_q, r0_shadow_d;
    logic          reg_write_q, reg_write_d;
    logic [3:0]    reg_addr_q, reg_addr_d;
    logic [15:0]   data_write_q, data_write_d;
    logic [15:0]   r0_write_q, r0_write_d;
    logic          r0_changed_q, r0_changed_d;

    logic          push;
    logic          pop;
    logic [3:0]    head_dest;
    logic [15:0]   head_data;
    logic [DEPTH-1:0] entry_valid;

    assign mem_ready = (count_q != FULL_CNT);
    assign push      = mem_valid && mem_ready;
    assign pop       = !alu_valid && (count_q != '0);
    assign head_dest = fifo_dest_q[rd_ptr_q];
    assign head_data = fifo_data_q[rd_ptr_q];

    always_comb begin
        reg_write_d  = 1'b0;
        reg_addr_d   = reg_addr_q;
        data_write_d = data_write_q;
        r0_write_d   = r0_write_q;
        if (alu_valid) begin
            reg_write_d = 1'b1;
            reg_addr_d  = alu_dest;
            if (alu_dest == 4'd0) begin
                // A write to R0 itself: the R0 lane and the data lane must agree.
                data_write_d = alu_r0_en ? alu_r0_data : alu_data;
                r0_write_d   = alu_r0_en ? alu_r0_data : alu_data;
            end else begin
                data_write_d = alu_data;
                r0_write_d   = alu_r0_en ? alu_r0_data : r0_shadow_q;
            end
        end else if (pop) begin
            reg_write_d  = 1'b1;
            reg_addr_d   = head_dest;
            data_write_d = head_data;
            r0_write_d   = (head_dest == 4'd0) ? head_data : r0_shadow_q;
        end
        r0_shadow_d  = reg_write_d ? r0_write_d : r0_shadow_q;
        r0_changed_d = reg_write_d && (r0_write_d != r0_shadow_q);
    end

    always_comb begin
        fifo_dest_d = fifo_dest_q;
        fifo_data_d = fifo_data_q;
        if (push) begin
            fifo_dest_d[wr_ptr_q] = mem_dest;
            fifo_data_d[wr_ptr_q] = mem_data;
        end
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry_valid
        logic [PW-1:0] offset;
        assign offset          = PW'(gi) - rd_ptr_q;
        assign entry_valid[gi] = ({1'b0, offset} < count_q);
    end

    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i]) begin
                busy_mask[fifo_dest_q[i]] = 1'b1;
            end
        end
        if (reg_write_q) begin
            busy_mask[reg_addr_q] = 1'b1;
        end
        if (r0_changed_q) begin
            busy_mask[0] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_dest_q[i] <= '0;
                fifo_data_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            r0_shadow_q  <= '0;
            reg_write_q  <= 1'b0;
            reg_addr_q   <= '0;
            data_write_q <= '0;
            r0_write_q   <= '0;
            r0_changed_q <= 1'b0;
        end else begin
            fifo_dest_q  <= fifo_dest_d;
            fifo_data_q  <= fifo_data_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            r0_shadow_q  <= r0_shadow_d;
            reg_write_q  <= reg_write_d;
            reg_addr_q   <= reg_addr_d;
            data_write_q <= data_write_d;
            r0_write_q   <= r0_write_d;
            r0_changed_q <= r0_changed_d;
        end
    end

    assign registerWrite = reg_write_q;
    assign regWriteLocal = reg_addr_q;
    assign dataWrite     = data_write_q;
    assign r0Write       = r0_write_q;
    assign pending_cnt   = count_q;

endmodule
`default_nettype wire

// File: tb/tb_writeback_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_writeback_unit
// Purpose  : Vector table, directed corner sequences and random run against
//            a queue-based reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_writeback_unit;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        alu_valid;
    logic [3:0]  alu_dest;
    logic [15:0] alu_data;
    logic        alu_r0_en;
    logic [15:0] alu_r0_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [3:0]  mem_dest;
    logic [15:0] mem_data;
    logic        registerWrite;
    logic [3:0]  regWriteLocal;
    logic [15:0] dataWrite;
    logic [15:0] r0Write;
    logic [15:0] busy_mask;
    logic [1:0]  pending_cnt;

    writeback_unit #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n),
        .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_data(alu_data),
        .alu_r0_en(alu_r0_en), .alu_r0_data(alu_r0_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_dest(mem_dest), .mem_data(mem_data),
        .registerWrite(registerWrite), .regWriteLocal(regWriteLocal),
        .dataWrite(dataWrite), .r0Write(r0Write),
        .busy_mask(busy_mask), .pending_cnt(pending_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        av;
        logic [3:0]  ad;
        logic [15:0] adat;
        logic        ren;
        logic [15:0] rdat;
        logic        mv;
        logic [3:0]  md;
        logic [15:0] mdat;
        logic        erw;
        logic [3:0]  eaddr;
        logic [15:0] edata;
        logic [15:0] er0;
        logic [15:0] ebusy;
        logic [1:0]  epend;
        logic        erdy;
    } vec_t;

    vec_t vecs [10];
    int   n_pass  = 0;
    int   n_total = 0;

    logic [3:0]  m_dq [$];
    logic [15:0] m_xq [$];
    logic [15:0] m_shadow;
    logic        m_rw;
    logic [3:0]  m_addr;
    logic [15:0] m_data;
    logic [15:0] m_r0;
    logic        m_changed;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic chk_all(input string tag, input logic rw, input logic [3:0] addr,
                           input logic [15:0] data, input logic [15:0] r0,
                           input logic [15:0] busy, input logic [1:0] pend, input logic rdy);
        chk({tag, ".registerWrite"}, 32'(registerWrite), 32'(rw));
        chk({tag, ".regWriteLocal"}, 32'(regWriteLocal), 32'(addr));
        chk({tag, ".dataWrite"},     32'(dataWrite),     32'(data));
        chk({tag, ".r0Write"},       32'(r0Write),       32'(r0));
        chk({tag, ".busy_mask"},     32'(busy_mask),     32'(busy));
        chk({tag, ".pending_cnt"},   32'(pending_cnt),   32'(pend));
        chk({tag, ".mem_ready"},     32'(mem_ready),     32'(rdy));
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; alu_dest = '0; alu_data = '0; alu_r0_en = 1'b0; alu_r0_data = '0;
        mem_valid = 1'b0; mem_dest = '0; mem_data = '0;
    endtask

    task automatic set_alu(input logic v, input logic [3:0] d, input logic [15:0] x,
                           input logic e, input logic [15:0] r);
        alu_valid = v; alu_dest = d; alu_data = x; alu_r0_en = e; alu_r0_data = r;
    endtask

    task automatic set_mem(input logic v, input logic [3:0] d, input logic [15:0] x);
        mem_valid = v; mem_dest = d; mem_data = x;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    // Reference: predicts post-edge outputs from the current inputs.
    task automatic model_step();
        int        pre_size;
        logic [15:0] old_shadow;
        logic [3:0]  d;
        logic [15:0] x;
        pre_size   = m_dq.size();
        old_shadow = m_shadow;
        m_rw       = 1'b0;
        if (alu_valid) begin
            m_rw   = 1'b1;
            m_addr = alu_dest;
            if (alu_dest == 4'd0) begin
                m_data = alu_r0_en ? alu_r0_data : alu_data;
                m_r0   = m_data;
            end else begin
                m_data = alu_data;
                m_r0   = alu_r0_en ? alu_r0_data : m_shadow;
            end
        end else if (pre_size > 0) begin
            d = m_dq.pop_front();
            x = m_xq.pop_front();
            m_rw   = 1'b1;
            m_addr = d;
            m_data = x;
            m_r0   = (d == 4'd0) ? x : m_shadow;
        end
        if (m_rw) m_shadow = m_r0;
        m_changed = m_rw && (m_r0 != old_shadow);
        if (mem_valid && pre_size != DEPTH) begin
            m_dq.push_back(mem_dest);
            m_xq.push_back(mem_data);
        end
    endtask

    function automatic logic [15:0] model_busy();
        logic [15:0] b;
        b = '0;
        foreach (m_dq[i]) b[m_dq[i]] = 1'b1;
        if (m_rw) b[m_addr] = 1'b1;
        if (m_changed) b[0] = 1'b1;
        return b;
    endfunction

    initial begin
        vecs[0] = '{1'b1,4'd3,16'h1234,1'b0,16'h0000, 1'b0,4'd0,16'h0000, 1'b1,4'd3,16'h1234,16'h0000,16'h0008,2'd0,1'b1};
        vecs[1] = '{1'b1,4'd5,16'hAAAA,1'b1,16'hBEEF, 1'b0,4'd0,16'h0000, 1'b1,4'd5,16'hAAAA,16'hBEEF,16'h0021,2'd0,1'b1};
        vecs[2] = '{1'b1,4'd6,16'h0001,1'b0,16'h0000, 1'b0,4'd0,16'h0000, 1'b1,4'd6,16'h0001,16'hBEEF,16'h0040,2'd0,1'b1};
        vecs[3] = '{1'b0,4'd0,16'h0000,1'b0,16'h0000, 1'b1,4'd0,16'h5A5A, 1'b0,4'd6,16'h0001,16'hBEEF,16'h0001,2'd1,1'b1};
        vecs[4] = '{1'b0,4'd0,16'h0000,1'b0,16'h0000, 1'b0,4'd0,16'h0000, 1'b1,4'd0,16'h5A5A,16'h5A5A,16'h0001,2'd0,1'b1};
        vecs[5] = '{1'b1,4'd7,16'h0777,1'b0,16'h0000, 1'b0,4'd0,16'h0000, 1'b1,4'd7,16'h0777,16'h5A5A,16'h0080,2'd0,1'b1};
        vecs[6] = '{1'b0,4'd0,16'h0000,1'b0,16'h0000, 1'b0,4'd0,16'h0000, 1'b0,4'd7,16'h0777,16'h5A5A,16'h0000,2'd0,1'b1};
        vecs[7] = '{1'b1,4'd0,16'h1111,1'b1,16'h2222, 1'b0,4'd0,16'h0000, 1'b1,4'd0,16'h2222,16'h2222,16'h0001,2'd0,1'b1};
        vecs[8] = '{1'b1,4'd0,16'h3333,1'b0,16'h0000, 1'b0,4'd0,16'h0000, 1'b1,4'd0,16'h3333,16'h3333,16'h0001,2'd0,1'b1};
        vecs[9] = '{1'b0,4'd0,16'h0000,1'b0,16'h0000, 1'b0,4'd0,16'h0000, 1'b0,4'd0,16'h3333,16'h3333,16'h0000,2'd0,1'b1};

        do_reset();
        chk_all("reset", 1'b0, 4'd0, 16'h0, 16'h0, 16'h0, 2'd0, 1'b1);

        for (int i = 0; i < 10; i++) begin
            set_alu(vecs[i].av, vecs[i].ad, vecs[i].adat, vecs[i].ren, vecs[i].rdat);
            set_mem(vecs[i].mv, vecs[i].md, vecs[i].mdat);
            tick();
            chk_all($sformatf("vec%0d", i), vecs[i].erw, vecs[i].eaddr, vecs[i].edata,
                    vecs[i].er0, vecs[i].ebusy, vecs[i].epend, vecs[i].erdy);
        end

        // ALU holds the port while loads fill the buffer, then the buffer drains in order.
        set_alu(1'b1, 4'd2, 16'h2000, 1'b0, 16'h0);
        set_mem(1'b1, 4'd1, 16'h0101);
        tick(); chk_all("fill1", 1'b1, 4'd2, 16'h2000, 16'h3333, 16'h0006, 2'd1, 1'b1);
        set_mem(1'b1, 4'd2, 16'h0202);
        tick(); chk_all("fill2", 1'b1, 4'd2, 16'h2000, 16'h3333, 16'h0006, 2'd2, 1'b0);
        set_mem(1'b1, 4'd4, 16'h0404);
        tick(); chk_all("full", 1'b1, 4'd2, 16'h2000, 16'h3333, 16'h0006, 2'd2, 1'b0);
        set_alu(1'b0, 4'd0, 16'h0, 1'b0, 16'h0);
        tick(); chk_all("drain1", 1'b1, 4'd1, 16'h0101, 16'h3333, 16'h0006, 2'd1, 1'b1);
        tick(); chk_all("drain2", 1'b1, 4'd2, 16'h0202, 16'h3333, 16'h0014, 2'd1, 1'b1);
        set_mem(1'b0, 4'd0, 16'h0);
        tick(); chk_all("drain4", 1'b1, 4'd4, 16'h0404, 16'h3333, 16'h0010, 2'd0, 1'b1);
        tick(); chk_all("drained", 1'b0, 4'd4, 16'h0404, 16'h3333, 16'h0000, 2'd0, 1'b1);

        // Streaming push+pop at count 1, pointers wrap several times.
        for (int k = 0; k < 10; k++) begin
            set_mem(1'b1, 4'(k + 1), 16'hC000 + 16'(k));
            tick();
            chk($sformatf("wrap%0d.pend", k), 32'(pending_cnt), 32'd1);
            chk($sformatf("wrap%0d.rw", k), 32'(registerWrite), (k == 0) ? 32'd0 : 32'd1);
            if (k > 0) begin
                chk($sformatf("wrap%0d.addr", k), 32'(regWriteLocal), 32'(k));
                chk($sformatf("wrap%0d.data", k), 32'(dataWrite), 32'(16'hC000 + 16'(k - 1)));
            end
        end
        set_mem(1'b0, 4'd0, 16'h0);
        tick();
        chk("wrap_last.addr", 32'(regWriteLocal), 32'd10);
        chk("wrap_last.data", 32'(dataWrite), 32'h0000C009);
        chk("wrap_last.pend", 32'(pending_cnt), 32'd0);

        // Asynchronous reset with two buffered loads and a write in flight.
        set_alu(1'b1, 4'd9, 16'h9999, 1'b1, 16'h7777);
        set_mem(1'b1, 4'd3, 16'h0303);
        tick();
        set_mem(1'b1, 4'd5, 16'h0505);
        tick();
        chk("pre_rst.pend", 32'(pending_cnt), 32'd2);
        chk("pre_rst.rw", 32'(registerWrite), 32'd1);
        idle_inputs();
        #2 reset_n = 1'b0;
        #1 chk_all("async_rst", 1'b0, 4'd0, 16'h0, 16'h0, 16'h0, 2'd0, 1'b1);
        @(posedge clk);
        #1 reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_all($sformatf("post_rst%0d", k), 1'b0, 4'd0, 16'h0, 16'h0, 16'h0, 2'd0, 1'b1);
        end

        // Random traffic against the queue model.
        do_reset();
        m_dq.delete(); m_xq.delete();
        m_shadow = '0; m_rw = 1'b0; m_addr = '0; m_data = '0; m_r0 = '0; m_changed = 1'b0;
        for (int c = 0; c < 400; c++) begin
            set_alu($urandom_range(0, 2) == 0, 4'($urandom_range(0, 15)), 16'($urandom),
                    $urandom_range(0, 3) == 0, 16'($urandom));
            set_mem($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), 16'($urandom));
            model_step();
            tick();
            chk_all($sformatf("rnd%0d", c), m_rw, m_addr, m_data, m_r0, model_busy(),
                    2'(m_dq.size()), m_dq.size() != DEPTH);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
